camera_cfg_seq: RTL

Sequencer that walks the camera register-configuration ROM and issues each entry to the SCCB master as a write transaction. It supports per-entry write, delay, no-op and end commands, retries writes that are NACKed, and reports completion and errors. It sits between system bring-up control (start) and the SCCB master, and is the only driver of the ROM address.

---
 rtl/camera_cfg_seq_pkg.sv | 31 +++
 rtl/camera_cfg_seq_delay_timer.sv | 29 ++
 rtl/camera_cfg_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/camera_cfg_seq_pkg.sv
// Shared definitions for the camera configuration sequencer: ROM command
// codes, FSM state encoding and the delay-length helper.
package camera_cfg_seq_pkg;

    // ROM command field encoding (also used to build ROM tables)
    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_DLY = 2'b10;
    localparam logic [1:0] CMD_END = 2'b11;

    // Width of the delay down-counter
    localparam int DLY_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WRITE,
        ST_GAP,
        ST_DELAY,
        ST_NEXT,
        ST_FIN
    } state_t;

    // Number of cycles a delay entry spends waiting
    function automatic logic [DLY_W-1:0] delay_cycles(input logic [7:0] units,
                                                       input int unit_cycles);
        return DLY_W'(units) * DLY_W'(unit_cycles);
    endfunction

endpackage

// File: rtl/camera_cfg_seq_delay_timer.sv
// Loadable 24-bit down-counter. o_expire is high in the enabled cycle in
// which the count reads 1, so a load of N gives exactly N enabled cycles.
module camera_cfg_seq_delay_timer
    import camera_cfg_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DLY_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expire
);

    logic [DLY_W-1:0] r_count;

    // Count register: load has priority, otherwise count down while enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = i_en && (r_count == DLY_W'(1));

endmodule

// File: rtl/camera_cfg_seq.sv
// Camera register-configuration sequencer. Walks the combinational config
// ROM from entry 0, issues WRITE entries to the SCCB master (with retry on
// NACK), honours DELAY/NOP/END entries and reports done/error.
module camera_cfg_seq
    import camera_cfg_seq_pkg::*;
#(
    parameter logic [7:0] LAST_ADDR  = 8'h5f,
    parameter int         DELAY_UNIT = 10000,
    parameter int         MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] romaddr,
    input  logic [1:0] t_cmd,
    input  logic [7:0] t_addr,
    input  logic [7:0] t_data,
    output logic       sccb_req,
    output logic [7:0] sccb_addr,
    output logic [7:0] sccb_data,
    input  logic       sccb_ack,
    input  logic       sccb_nack,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    state_t     r_state, r_state_next;
    logic [7:0] r_romaddr, r_romaddr_next;
    logic [1:0] r_cmd, r_cmd_next;
    logic [7:0] r_addr, r_addr_next;
    logic [7:0] r_data, r_data_next;
    logic       r_req, r_req_next;
    logic [7:0] r_sccb_addr, r_sccb_addr_next;
    logic [7:0] r_sccb_data, r_sccb_data_next;
    logic [3:0] r_attempts, r_attempts_next;
    logic       r_busy, r_busy_next;
    logic       r_done, r_done_next;
    logic       r_error, r_error_next;

    logic             w_tmr_load;
    logic             w_tmr_en;
    logic             w_tmr_expire;
    logic [DLY_W-1:0] w_tmr_val;
    logic [3:0]       w_attempts_inc;

    assign w_tmr_val      = delay_cycles(r_data, DELAY_UNIT);
    assign w_attempts_inc = r_attempts + 4'd1;

    camera_cfg_seq_delay_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_expire   (w_tmr_expire)
    );

    // State and output registers; reset abandons any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_romaddr   <= '0;
            r_cmd       <= CMD_NOP;
            r_addr      <= '0;
            r_data      <= '0;
            r_req       <= 1'b0;
            r_sccb_addr <= '0;
            r_sccb_data <= '0;
            r_attempts  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= r_state_next;
            r_romaddr   <= r_romaddr_next;
            r_cmd       <= r_cmd_next;
            r_addr      <= r_addr_next;
            r_data      <= r_data_next;
            r_req       <= r_req_next;
            r_sccb_addr <= r_sccb_addr_next;
            r_sccb_data <= r_sccb_data_next;
            r_attempts  <= r_attempts_next;
            r_busy      <= r_busy_next;
            r_done      <= r_done_next;
            r_error     <= r_error_next;
        end
    end

    // Next-state and next-output logic of the sequencer
    always_comb begin
        r_state_next     = r_state;
        r_romaddr_next   = r_romaddr;
        r_cmd_next       = r_cmd;
        r_addr_next      = r_addr;
        r_data_next      = r_data;
        r_req_next       = r_req;
        r_sccb_addr_next = r_sccb_addr;
        r_sccb_data_next = r_sccb_data;
        r_attempts_next  = r_attempts;
        r_busy_next      = r_busy;
        r_done_next      = 1'b0;
        r_error_next     = r_error;
        w_tmr_load       = 1'b0;
        w_tmr_en         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    r_romaddr_next = '0;
                    r_busy_next    = 1'b1;
                    r_error_next   = 1'b0;
                    r_state_next   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // ROM output has settled for the current romaddr
                r_cmd_next   = t_cmd;
                r_addr_next  = t_addr;
                r_data_next  = t_data;
                r_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (r_cmd)
                    CMD_WR: begin
                        r_sccb_addr_next = r_addr;
                        r_sccb_data_next = r_data;
                        r_req_next       = 1'b1;
                        r_attempts_next  = '0;
                        r_state_next     = ST_WRITE;
                    end
                    CMD_DLY: begin
                        if (r_data != 8'd0) begin
                            w_tmr_load   = 1'b1;
                            r_state_next = ST_DELAY;
                        end else begin
                            r_state_next = ST_NEXT;
                        end
                    end
                    CMD_NOP: r_state_next = ST_NEXT;
                    CMD_END: r_state_next = ST_FIN;
                endcase
            end
            ST_WRITE: begin
                // NACK takes priority over a simultaneous ACK
                if (sccb_nack) begin
                    r_req_next      = 1'b0;
                    r_attempts_next = w_attempts_inc;
                    if (w_attempts_inc < RETRY_LIMIT) begin
                        r_state_next = ST_GAP;
                    end else begin
                        r_error_next = 1'b1;
                        r_state_next = ST_FIN;
                    end
                end else if (sccb_ack) begin
                    r_req_next   = 1'b0;
                    r_state_next = ST_NEXT;
                end
            end
            ST_GAP: begin
                // One idle cycle, then retry with unchanged addr/data
                r_req_next   = 1'b1;
                r_state_next = ST_WRITE;
            end
            ST_DELAY: begin
                w_tmr_en = 1'b1;
                if (w_tmr_expire) begin
                    r_state_next = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if ((r_romaddr == LAST_ADDR) || (r_romaddr == 8'hff)) begin
                    r_state_next = ST_FIN;
                end else begin
                    r_romaddr_next = r_romaddr + 8'd1;
                    r_state_next   = ST_FETCH;
                end
            end
            ST_FIN: begin
                r_done_next  = 1'b1;
                r_busy_next  = 1'b0;
                r_state_next = ST_IDLE;
            end
            default: r_state_next = ST_IDLE;
        endcase
    end

    assign romaddr   = r_romaddr;
    assign sccb_req  = r_req;
    assign sccb_addr = r_sccb_addr;
    assign sccb_data = r_sccb_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;

endmodule
